// File: rtl/bcd_count_controller.sv
// bcd_count_controller: start/stop/clear controlled 4-digit BCD counter with multiplexed display scan
// Ports:
//   clk, rst            single clock, asynchronous active-high reset
//   start, stop, clear  level-sampled commands, priority clear > stop > start
//   digits              four BCD nibbles, [3:0] ones .. [15:12] thousands
//   running             registered, high while the state is RUN
//   overflow            one-cycle pulse on the 9999 -> 0000 wrap
//   scan_sel            digit index currently presented for display
//   scan_digit          nibble of digits selected by scan_sel
module bcd_count_controller #(
   parameter int TICK_DIV = 50000000,
   parameter int SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic        clear,
   output logic [15:0] digits,
   output logic        running,
   output logic        overflow,
   output logic [1:0]  scan_sel,
   output logic [3:0]  scan_digit
);
   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [15:0]   digits_q, digits_d, inc;
   logic          running_q, overflow_q, overflow_d, carry;
   logic [SW-1:0] scan_cnt_q;
   logic [1:0]    scan_sel_q;
   // ripple-carry BCD increment; a nibble at 9 rolls to 0 and carries upward
   always_comb begin
      inc = digits_q;
      carry = 1'b1;
      for (int n = 0; n < 4; n++) begin
         inc[4*n +: 4] = carry ? (digits_q[4*n +: 4] == 4'd9 ? 4'd0 : digits_q[4*n +: 4] + 4'd1) : digits_q[4*n +: 4];
         carry = carry & (digits_q[4*n +: 4] == 4'd9);
      end
   end
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      digits_d = digits_q;
      overflow_d = 1'b0;
      case (state_q)
         IDLE: begin
            presc_d = '0;
            digits_d = '0;
            state_d = (start && !stop && !clear) ? RUN : IDLE;
         end
         RUN: begin
            if (clear) begin
               state_d = IDLE;
               presc_d = '0;
               digits_d = '0;
            end else if (stop) begin
               state_d = PAUSE;
            end else if (presc_q == PRESC_MAX) begin
               presc_d = '0;
               digits_d = inc;
               overflow_d = digits_q == 16'h9999;
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end
         PAUSE: begin
            if (clear) begin
               state_d = IDLE;
               presc_d = '0;
               digits_d = '0;
            end else if (start) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
            presc_d = '0;
            digits_d = '0;
         end
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         presc_q <= '0;
         digits_q <= '0;
         running_q <= 1'b0;
         overflow_q <= 1'b0;
         scan_cnt_q <= '0;
         scan_sel_q <= '0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         digits_q <= digits_d;
         running_q <= state_d == RUN;
         overflow_q <= overflow_d;
         scan_cnt_q <= scan_cnt_q == SCAN_MAX ? '0 : scan_cnt_q + SW'(1);
         scan_sel_q <= scan_sel_q + 2'(scan_cnt_q == SCAN_MAX);
      end
   end
   assign digits = digits_q;
   assign running = running_q;
   assign overflow = overflow_q;
   assign scan_sel = scan_sel_q;
   assign scan_digit = digits_q[4*scan_sel_q +: 4];
endmodule

// File: tb/tb_bcd_count_controller.sv
// tb_bcd_count_controller: directed self-checking bench for bcd_count_controller (TICK_DIV=4, SCAN_DIV=2)
module tb_bcd_count_controller;
   logic        clk, rst, start, stop, clear;
   logic [15:0] digits;
   logic        running, overflow;
   logic [1:0]  scan_sel;
   logic [3:0]  scan_digit;
   int checks = 0;
   int failures = 0;
   bcd_count_controller #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
      .digits(digits), .running(running), .overflow(overflow),
      .scan_sel(scan_sel), .scan_digit(scan_digit)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic test_reset;
      rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
      step(3);
      checks++; if (digits !== 16'h0000) begin failures++; $display("FAIL reset_digits got=%h exp=0000", digits); end
      checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
      checks++; if (scan_sel !== 2'd0) begin failures++; $display("FAIL reset_scan_sel got=%0d exp=0", scan_sel); end
      rst = 1'b0;
      step(4);
      checks++; if (running !== 1'b0 || digits !== 16'h0000) begin failures++; $display("FAIL idle_after_reset running=%b digits=%h exp 0/0000", running, digits); end
   endtask
   task automatic test_count;
      start = 1'b1;
      step(1);
      start = 1'b0;
      checks++; if (running !== 1'b1) begin failures++; $display("FAIL start_running got=%b exp=1", running); end
      step(3);
      checks++; if (digits !== 16'h0000) begin failures++; $display("FAIL count_s3 got=%h exp=0000", digits); end
      step(1);
      checks++; if (digits !== 16'h0001) begin failures++; $display("FAIL count_s4 got=%h exp=0001", digits); end
      step(7);
      checks++; if (digits !== 16'h0002) begin failures++; $display("FAIL count_s11 got=%h exp=0002", digits); end
      step(1);
      checks++; if (digits !== 16'h0003) begin failures++; $display("FAIL count_s12 got=%h exp=0003", digits); end
   endtask
   task automatic test_wrap;
      int ovf_seen = 0;
      int bad_nib = 0;
      step(4 * 96);
      checks++; if (digits !== 16'h0099) begin failures++; $display("FAIL preload_0099 got=%h exp=0099", digits); end
      step(4);
      checks++; if (digits !== 16'h0100 || overflow !== 1'b0) begin failures++; $display("FAIL carry_0100 digits=%h ovf=%b exp 0100/0", digits, overflow); end
      for (int i = 0; i < 4 * 9899; i++) begin
         step(1);
         if (overflow) ovf_seen++;
         for (int k = 0; k < 4; k++) if (digits[4*k +: 4] > 4'd9) bad_nib++;
      end
      checks++; if (digits !== 16'h9999) begin failures++; $display("FAIL reach_9999 got=%h exp=9999", digits); end
      checks++; if (ovf_seen !== 0) begin failures++; $display("FAIL early_overflow got=%0d exp=0", ovf_seen); end
      checks++; if (bad_nib !== 0) begin failures++; $display("FAIL nibble_range got=%0d exp=0", bad_nib); end
      step(3);
      checks++; if (digits !== 16'h9999 || overflow !== 1'b0) begin failures++; $display("FAIL pre_wrap digits=%h ovf=%b exp 9999/0", digits, overflow); end
      step(1);
      checks++; if (digits !== 16'h0000 || overflow !== 1'b1 || running !== 1'b1) begin failures++; $display("FAIL wrap digits=%h ovf=%b run=%b exp 0000/1/1", digits, overflow, running); end
      step(1);
      checks++; if (overflow !== 1'b0 || digits !== 16'h0000) begin failures++; $display("FAIL wrap_pulse_width ovf=%b digits=%h exp 0/0000", overflow, digits); end
   endtask
   task automatic test_pause;
      int held_bad = 0;
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      checks++; if (running !== 1'b0 || digits !== 16'h0000) begin failures++; $display("FAIL clear_to_idle run=%b digits=%h exp 0/0000", running, digits); end
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(4);
      checks++; if (digits !== 16'h0001) begin failures++; $display("FAIL pause_first_tick got=%h exp=0001", digits); end
      step(2);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      checks++; if (running !== 1'b0 || digits !== 16'h0001) begin failures++; $display("FAIL enter_pause run=%b digits=%h exp 0/0001", running, digits); end
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (digits !== 16'h0001 || running !== 1'b0) held_bad++;
      end
      checks++; if (held_bad !== 0) begin failures++; $display("FAIL pause_hold got=%0d bad cycles exp=0", held_bad); end
      start = 1'b1;
      step(1);
      start = 1'b0;
      checks++; if (running !== 1'b1 || digits !== 16'h0001) begin failures++; $display("FAIL resume run=%b digits=%h exp 1/0001", running, digits); end
      step(1);
      checks++; if (digits !== 16'h0001) begin failures++; $display("FAIL resume_r1 got=%h exp=0001", digits); end
      step(1);
      checks++; if (digits !== 16'h0002) begin failures++; $display("FAIL resume_r2 got=%h exp=0002", digits); end
   endtask
   task automatic test_all_cmds;
      step(3);
      start = 1'b1; stop = 1'b1; clear = 1'b1;
      step(1);
      start = 1'b0; stop = 1'b0; clear = 1'b0;
      checks++; if (running !== 1'b0 || digits !== 16'h0000 || overflow !== 1'b0) begin failures++; $display("FAIL all_cmds run=%b digits=%h ovf=%b exp 0/0000/0", running, digits, overflow); end
      step(5);
      checks++; if (running !== 1'b0 || digits !== 16'h0000) begin failures++; $display("FAIL all_cmds_idle run=%b digits=%h exp 0/0000", running, digits); end
   endtask
   task automatic test_scan;
      int waited = 0;
      logic [1:0] prev;
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(4936);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      checks++; if (digits !== 16'h1234) begin failures++; $display("FAIL scan_preload got=%h exp=1234", digits); end
      prev = scan_sel;
      step(1);
      while (!(scan_sel == 2'd0 && prev != 2'd0) && waited < 10) begin
         prev = scan_sel;
         step(1);
         waited++;
      end
      checks++; if (waited >= 10) begin failures++; $display("FAIL scan_sync_timeout got=%0d exp<10", waited); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (scan_sel !== 2'(i) || scan_digit !== 4'(4 - (i % 4))) begin failures++; $display("FAIL scan_step%0d_a sel=%0d dig=%0d exp %0d/%0d", i, scan_sel, scan_digit, i % 4, 4 - (i % 4)); end
         step(1);
         checks++; if (scan_sel !== 2'(i) || scan_digit !== 4'(4 - (i % 4))) begin failures++; $display("FAIL scan_step%0d_b sel=%0d dig=%0d exp %0d/%0d", i, scan_sel, scan_digit, i % 4, 4 - (i % 4)); end
         step(1);
      end
   endtask
   task automatic test_async_reset;
      int idle_bad = 0;
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(6);
      checks++; if (digits !== 16'h0001 || running !== 1'b1) begin failures++; $display("FAIL pre_async digits=%h run=%b exp 0001/1", digits, running); end
      #3 rst = 1'b1;
      #1;
      checks++; if (digits !== 16'h0000 || running !== 1'b0 || overflow !== 1'b0 || scan_sel !== 2'd0) begin failures++; $display("FAIL async_reset digits=%h run=%b ovf=%b sel=%0d exp 0000/0/0/0", digits, running, overflow, scan_sel); end
      #1 rst = 1'b0;
      step(1);
      for (int i = 0; i < 8; i++) begin
         step(1);
         if (running !== 1'b0 || digits !== 16'h0000 || overflow !== 1'b0) idle_bad++;
      end
      checks++; if (idle_bad !== 0) begin failures++; $display("FAIL post_async_idle got=%0d bad cycles exp=0", idle_bad); end
   endtask
   initial begin
      test_reset();
      test_count();
      test_wrap();
      test_pause();
      test_all_cmds();
      test_scan();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
